// File: rtl/reg_port_arbiter.sv
// reg_port_arbiter
//   Shares the UART register-file access port between two requesters:
//   requester 0 is the UART command path, requester 1 is the local
//   debug/CPU bus bridge. Arbitration is round-robin. Only one transaction
//   is outstanding at a time. Each response is routed back only to the
//   requester that issued it.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_req_valid/we      per-requester request valid / write enable (bit k = requester k)
//   i_req_addr/wdata    per-requester address / write data, packed (slice k = requester k)
//   o_req_ready         per-requester accept (combinational, IDLE only)
//   o_rsp_valid         per-requester one-cycle response strobe
//   o_rsp_rdata         shared response data, qualified by o_rsp_valid
//   o_rwaddr            register address to the register file (holds last value)
//   o_rd_req, o_wr_req  one-cycle read / write strobes
//   o_write_reg         write data to the register file (holds last value)
//   o_fifo_fetch        RX FIFO pop, issued alongside a read of FIFO_ADDR
//   i_read_reg          read data, valid RD_LATENCY cycles after o_rd_req
module reg_port_arbiter #(
   parameter int                ADDR_W     = 3,
   parameter int                DATA_W     = 8,
   parameter int                RD_LATENCY = 1,
   parameter logic [ADDR_W-1:0] FIFO_ADDR  = ADDR_W'(2)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [1:0]            i_req_valid,
   input  logic [1:0]            i_req_we,
   input  logic [2*ADDR_W-1:0]   i_req_addr,
   input  logic [2*DATA_W-1:0]   i_req_wdata,
   output logic [1:0]            o_req_ready,
   output logic [1:0]            o_rsp_valid,
   output logic [DATA_W-1:0]     o_rsp_rdata,
   output logic [ADDR_W-1:0]     o_rwaddr,
   output logic                  o_rd_req,
   output logic                  o_wr_req,
   output logic [DATA_W-1:0]     o_write_reg,
   output logic                  o_fifo_fetch,
   input  logic [DATA_W-1:0]     i_read_reg
);

   generate
      if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_latency
         $error("reg_port_arbiter: RD_LATENCY must be in the range 1..7");
      end
   endgenerate

   // Counter holds the remaining WAIT_RD cycles minus one; zero means the
   // register file presents the read data in the current cycle.
   localparam logic [2:0] LAT_INIT = 3'(RD_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t              state;
   logic                last_grant;
   logic                owner;
   logic                we_q;
   logic [2:0]          lat_cnt;

   logic                any_valid;
   logic                grant;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   // Winner: on contention the requester that did not win last time,
   // otherwise whichever one is valid.
   always_comb begin
      any_valid = |i_req_valid;
      grant     = (&i_req_valid) ? ~last_grant : i_req_valid[1];
      sel_we    = grant ? i_req_we[1] : i_req_we[0];
      sel_addr  = grant ? i_req_addr[2*ADDR_W-1:ADDR_W] : i_req_addr[ADDR_W-1:0];
      sel_wdata = grant ? i_req_wdata[2*DATA_W-1:DATA_W] : i_req_wdata[DATA_W-1:0];
   end

   assign o_req_ready = (state == IDLE && any_valid) ? (grant ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         last_grant   <= 1'b1;
         owner        <= 1'b0;
         we_q         <= 1'b0;
         lat_cnt      <= '0;
         o_rsp_valid  <= '0;
         o_rsp_rdata  <= '0;
         o_rwaddr     <= '0;
         o_rd_req     <= 1'b0;
         o_wr_req     <= 1'b0;
         o_write_reg  <= '0;
         o_fifo_fetch <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  owner        <= grant;
                  last_grant   <= grant;
                  we_q         <= sel_we;
                  o_rwaddr     <= sel_addr;
                  o_write_reg  <= sel_we ? sel_wdata : '0;
                  o_wr_req     <= sel_we;
                  o_rd_req     <= ~sel_we;
                  o_fifo_fetch <= ~sel_we && (sel_addr == FIFO_ADDR);
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               o_rd_req     <= 1'b0;
               o_wr_req     <= 1'b0;
               o_fifo_fetch <= 1'b0;
               if (we_q) begin
                  o_rsp_valid <= owner ? 2'b10 : 2'b01;
                  o_rsp_rdata <= '0;
                  state       <= RESP;
               end else begin
                  lat_cnt <= LAT_INIT;
                  state   <= WAIT_RD;
               end
            end
            WAIT_RD: begin
               if (lat_cnt == 3'd0) begin
                  o_rsp_valid <= owner ? 2'b10 : 2'b01;
                  o_rsp_rdata <= i_read_reg;
                  state       <= RESP;
               end else begin
                  lat_cnt <= lat_cnt - 3'd1;
               end
            end
            RESP: begin
               o_rsp_valid <= '0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   ap_strobe_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(o_rd_req && o_wr_req));
   ap_rsp_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      $onehot0(o_rsp_valid));
   ap_ready_idle: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (o_req_ready != 2'b00) |-> (state == IDLE));

endmodule

// File: doc/reg_port_arbiter.md
Name: reg_port_arbiter

Overview:
- Shares the single UART register-file access port (address, read/write strobes, write data, read data, FIFO fetch) between two requesters.
- Requester 0 is the UART command path. Requester 1 is the local debug/CPU bus bridge.
- Arbitration is round-robin. One transaction is outstanding at a time.
- Read data and write acknowledges are routed back only to the requester that issued the transaction.

Parameters:
- ADDR_W, 3: register address width; matches the reg_rwaddr encoding.
- DATA_W, 8: register data width.
- RD_LATENCY, 1: cycles from the o_rd_req pulse to valid i_read_reg. Legal range 1..7. A value of 0 is illegal and is flagged by an elaboration-time assertion.
- FIFO_ADDR, 3'd2: address of the RX FIFO data register. A read of this address also pulses o_fifo_fetch.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  2  per-requester request valid
- i_req_we  in  2  per-requester write enable; 1 = write, 0 = read
- i_req_addr  in  2xADDR_W  per-requester register address
- i_req_wdata  in  2xDATA_W  per-requester write data
- o_req_ready  out  2  per-requester accept
- o_rsp_valid  out  2  per-requester response strobe
- o_rsp_rdata  out  DATA_W  response data; shared bus, qualified by o_rsp_valid
- o_rwaddr  out  ADDR_W  register address to the register file
- o_rd_req  out  1  read strobe
- o_wr_req  out  1  write strobe
- o_write_reg  out  DATA_W  write data to the register file
- o_fifo_fetch  out  1  RX FIFO pop strobe
- i_read_reg  in  DATA_W  read data from the register file

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE.
  - last_grant = 1, so requester 0 has priority on the first contest.
- State machine: IDLE -> ISSUE -> (WAIT_RD) -> RESP -> IDLE.
- IDLE:
  - Winner selection: if both requesters are valid, grant goes to the requester != last_grant. If only one is valid, grant goes to that one.
  - o_req_ready[winner] = 1, combinationally, only in IDLE. The loser's ready is 0.
  - Accept occurs on the edge where valid & ready are both high. On accept:
    - latch addr, we, wdata and owner;
    - set last_grant = owner;
    - go to ISSUE.
- Accept-edge register updates (o_rwaddr, o_write_reg, o_wr_req, o_rd_req, o_fifo_fetch are registered outputs, all loaded on the accept edge):
  - o_rwaddr = addr.
  - o_write_reg = wdata on a write; 0 on a read.
  - o_wr_req = we.
  - o_rd_req = !we.
  - o_fifo_fetch = !we && addr == FIFO_ADDR.
- ISSUE (cycle T):
  - Exactly one of o_rd_req / o_wr_req is high for this single cycle. o_fifo_fetch is high alongside o_rd_req when applicable.
  - All three strobes are cleared on the edge leaving ISSUE.
  - Write: go to RESP.
  - Read: load the latency counter and go to WAIT_RD.
- WAIT_RD:
  - Remains for RD_LATENCY cycles.
  - i_read_reg is captured on the edge ending cycle T+RD_LATENCY, then the FSM goes to RESP.
- RESP:
  - o_rsp_valid[owner] = 1 for exactly one cycle.
  - o_rsp_rdata = captured data on a read; 0 on a write.
  - Then go to IDLE.
- Response timing:
  - Write response: cycle T+1.
  - Read response: cycle T+RD_LATENCY+1.
- Address and data hold: o_rwaddr and o_write_reg keep their last value after a transaction, not cleared. o_rsp_rdata also holds its last value.
- Throughput:
  - Next accept is possible in the first IDLE cycle after RESP.
  - Minimum spacing is 3 cycles per write and RD_LATENCY+3 cycles per read.
- Requester rules:
  - Before acceptance, a requester may drop valid with no effect.
  - After acceptance, the requester must not present a new request until its response, though the arbiter does not check this.
  - Inputs are sampled only on the accept edge.
- Boundary conditions:
  - A request asserted in the RESP cycle waits for IDLE. The other requester then wins if valid (fairness).
  - Back-to-back requests from the same sole requester are granted every transaction.
  - Reset mid-transaction aborts it: no response is issued and strobes drop immediately (asynchronously).
- Assertions:
  - o_rd_req and o_wr_req are never both high.
  - o_rsp_valid is onehot0.
  - o_req_ready is nonzero only in IDLE.

Test Plan:
- Single write: req0 we=1 addr=3'd5 wdata=8'hA5 -> o_wr_req high 1 cycle with o_rwaddr=5, o_write_reg=A5; o_rsp_valid[0] the next cycle; o_rsp_valid[1] stays 0.
- Read, RD_LATENCY=1: req1 read addr=3'd4, register file returns 8'h3C at T+1 -> o_rsp_valid[1] at T+2 with o_rsp_rdata=3C; o_fifo_fetch stays 0.
- FIFO read: req0 read addr=FIFO_ADDR -> o_fifo_fetch and o_rd_req high in the same single cycle.
- Contention: both valid continuously, 4 transactions each -> grants alternate 0,1,0,1,... starting with 0 after reset; each response goes only to its owner.
- Latency sweep: RD_LATENCY=3, read returns 8'h77 -> response at exactly T+4; sampling at T+1/T+2 (dummy data 8'hFF) must not appear.
- Reset mid-read: assert i_rst_n=0 in WAIT_RD -> all outputs 0 immediately, no o_rsp_valid after release; the next request from req0 is granted first and completes normally.
